edge_word_collector: RTL and testbench



---
 rtl/edge_io_pkg.sv | 23 ++
 rtl/edge_word_fifo2.sv | 80 ++++++++
 rtl/edge_word_collector.sv | 182 ++++++++++++++++++
 tb/tb_edge_word_collector.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_io_pkg.sv
// Shared definitions for the edge I/O blocks: default slice width, collector
// state encoding and the word-length-to-beats clamp.
package edge_io_pkg;

    localparam int SLICE_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } collect_state_e;

    // A requested length of zero, or one longer than the word, means a full word.
    function automatic logic [7:0] clamp_beats(input logic [7:0] len, input logic [7:0] max_beats);
        logic [7:0] beats_s;
        if ((len == 8'd0) || (len > max_beats)) begin
            beats_s = max_beats;
        end else begin
            beats_s = len;
        end
        return beats_s;
    endfunction

endpackage

// File: rtl/edge_word_fifo2.sv
// Two-entry valid/ready FIFO with a registered, fall-through head. A push while
// full is accepted only if the head is popped in the same cycle; otherwise it is dropped.
module edge_word_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    logic [1:0]       count_r, count_s;
    logic [WIDTH-1:0] head_r, head_s;
    logic [WIDTH-1:0] tail_r, tail_s;

    assign out_valid = (count_r != 2'd0);
    assign full      = (count_r == 2'd2);
    assign out_data  = head_r;

    // Next occupancy and storage for every push/pop combination.
    always_comb begin
        count_s = count_r;
        head_s  = head_r;
        tail_s  = tail_r;
        case ({push, pop})
            2'b10: begin
                case (count_r)
                    2'd0: begin
                        head_s  = push_data;
                        count_s = 2'd1;
                    end
                    2'd1: begin
                        tail_s  = push_data;
                        count_s = 2'd2;
                    end
                    default: begin
                        count_s = count_r;
                    end
                endcase
            end
            2'b01: begin
                if (count_r == 2'd2) begin
                    head_s  = tail_r;
                    count_s = 2'd1;
                end else begin
                    count_s = 2'd0;
                end
            end
            2'b11: begin
                if (count_r == 2'd2) begin
                    head_s = tail_r;
                    tail_s = push_data;
                end else begin
                    head_s = push_data;
                end
            end
            default: begin
                count_s = count_r;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 2'd0;
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_s;
            head_r  <= head_s;
            tail_r  <= tail_s;
        end
    end

endmodule

// File: rtl/edge_word_collector.sv
// Serial-to-parallel edge receiver: assembles per-lane slices into words and queues them
// for the host. Optional word_count output when EDGE_COLLECT_WORD_COUNT_EN is defined.
module edge_word_collector
    import edge_io_pkg::*;
#(
    parameter int  LANES           = 1,
    parameter int  SLICE_W         = SLICE_W_DEF,
    parameter int  MAX_WORD_LENGTH = 32,
    localparam int MAX_BEATS       = MAX_WORD_LENGTH / SLICE_W,
    localparam int LEN_W           = $clog2(MAX_BEATS) + 1,
    localparam int WORD_W          = LANES * MAX_BEATS * SLICE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       word_len,
    input  logic                   shift_en,
    input  logic [0:LANES*SLICE_W-1] slice_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:WORD_W-1]      out_word,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    input  logic                   clr_err
`ifdef EDGE_COLLECT_WORD_COUNT_EN
    ,
    output logic [15:0]            word_count
`endif
);

    collect_state_e    state_r, state_s;
    logic [LEN_W-1:0]  cnt_r, cnt_s, len_r, len_s;
    logic [LEN_W-1:0]  len_clamp_s, base_cnt_s, base_len_s;
    logic [0:WORD_W-1] asm_r, asm_s, base_asm_s, ins_asm_s;
    logic              last_s, push_s, pop_s, drop_s, push_ok_s;
    logic              fifo_valid_s, fifo_full_s;
    logic              done_r, busy_r, overflow_r;

    assign len_clamp_s = LEN_W'(clamp_beats(8'(word_len), 8'(MAX_BEATS)));

    // A start inside COLLECT restarts the word, so the current beat builds on a clean base.
    always_comb begin
        if (start) begin
            base_cnt_s = {LEN_W{1'b0}};
            base_len_s = len_clamp_s;
            base_asm_s = {WORD_W{1'b0}};
        end else begin
            base_cnt_s = cnt_r;
            base_len_s = len_r;
            base_asm_s = asm_r;
        end
    end

    // Drop each lane's slice into its beat position of the assembly word.
    always_comb begin
        ins_asm_s = base_asm_s;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < MAX_BEATS; k++) begin
                if (LEN_W'(k) == base_cnt_s) begin
                    ins_asm_s[l*MAX_BEATS*SLICE_W + k*SLICE_W +: SLICE_W] = slice_in[l*SLICE_W +: SLICE_W];
                end else begin
                    ins_asm_s[l*MAX_BEATS*SLICE_W + k*SLICE_W +: SLICE_W] = base_asm_s[l*MAX_BEATS*SLICE_W + k*SLICE_W +: SLICE_W];
                end
            end
        end
    end

    assign last_s = (base_cnt_s == (base_len_s - LEN_W'(1)));

    // Collector next-state: beat counting and word completion.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
        asm_s   = asm_r;
        push_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = COLLECT;
                    cnt_s   = {LEN_W{1'b0}};
                    len_s   = len_clamp_s;
                    asm_s   = {WORD_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                len_s = base_len_s;
                if (shift_en) begin
                    asm_s = ins_asm_s;
                    if (last_s) begin
                        push_s  = 1'b1;
                        state_s = IDLE;
                        cnt_s   = {LEN_W{1'b0}};
                    end else begin
                        cnt_s = base_cnt_s + LEN_W'(1);
                    end
                end else begin
                    cnt_s = base_cnt_s;
                    asm_s = base_asm_s;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign pop_s     = fifo_valid_s & out_ready;
    assign drop_s    = push_s & fifo_full_s & ~pop_s;
    assign push_ok_s = push_s & ~drop_s;

    edge_word_fifo2 #(
        .WIDTH(WORD_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .push_data(ins_asm_s),
        .pop      (pop_s),
        .out_valid(fifo_valid_s),
        .out_data (out_word),
        .full     (fifo_full_s)
    );

    assign out_valid = fifo_valid_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign overflow  = overflow_r;

    // Collector state, status flags and the sticky drop flag (a new drop beats clr_err).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {LEN_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            asm_r      <= {WORD_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            asm_r   <= asm_s;
            done_r  <= push_s;
            busy_r  <= (state_s == COLLECT);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

`ifdef EDGE_COLLECT_WORD_COUNT_EN
    logic [15:0] word_count_r;

    assign word_count = word_count_r;

    // Saturating count of words that actually entered the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_r <= 16'd0;
        end else if (clr_err) begin
            word_count_r <= 16'd0;
        end else if (push_ok_s && (word_count_r != 16'hFFFF)) begin
            word_count_r <= word_count_r + 16'd1;
        end else begin
            word_count_r <= word_count_r;
        end
    end
`else
    logic unused_push_ok_s;
    assign unused_push_ok_s = push_ok_s;
`endif

endmodule

// File: tb/tb_edge_word_collector.sv
// Self-checking bench for edge_word_collector (LANES=2, SLICE_W=8, MAX_BEATS=4):
// vector table, directed corner sequences and a randomized run against a queue model.
module tb_edge_word_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  word_len;
    logic        shift_en;
    logic [0:15] slice_in;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_word;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        clr_err;
`ifdef EDGE_COLLECT_WORD_COUNT_EN
    logic [15:0] word_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_word_collector #(
        .LANES(2),
        .SLICE_W(8),
        .MAX_WORD_LENGTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .word_len (word_len),
        .shift_en (shift_en),
        .slice_in (slice_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .clr_err  (clr_err)
`ifdef EDGE_COLLECT_WORD_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    typedef struct {
        logic [2:0]        len;
        int                nbeats;
        logic [0:3][15:0]  sl;
        logic [63:0]       exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] len);
        start    = 1'b1;
        word_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] s);
        shift_en = 1'b1;
        slice_in = s;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic word2(input logic [15:0] a, input logic [15:0] b);
        do_start(3'd2);
        beat(a);
        beat(b);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Transaction-level model: slices gathered in a queue, words built from the layout rule.
    task automatic random_phase();
        logic [0:63] q[$];
        logic [15:0] bq[$];
        logic [0:63] w;
        logic [15:0] s;
        logic [15:0] wc;
        bit coll, ovf, done_e, pop, dropped, pushed;
        int tlen, L;
        coll = 1'b0; ovf = 1'b0; wc = 16'd0; tlen = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            start     = coll ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            word_len  = 3'($urandom_range(0, 7));
            shift_en  = ($urandom_range(0, 3) != 0);
            slice_in  = 16'($urandom);
            out_ready = (cyc % 64 < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
            clr_err   = ($urandom_range(0, 24) == 0);
            pop       = (q.size() > 0) && out_ready;
            L         = ((word_len == 3'd0) || (word_len > 3'd4)) ? 4 : int'(word_len);
            done_e = 1'b0; dropped = 1'b0; pushed = 1'b0; w = 64'd0;
            if (!coll) begin
                if (start) begin
                    coll = 1'b1;
                    bq.delete();
                    tlen = L;
                end
            end else begin
                if (start) begin
                    bq.delete();
                    tlen = L;
                end
                if (shift_en) begin
                    bq.push_back(slice_in);
                    if (bq.size() == tlen) begin
                        done_e = 1'b1;
                        coll   = 1'b0;
                        for (int k = 0; k < tlen; k++) begin
                            s = bq[k];
                            w[k*8 +: 8]      = s[15:8];
                            w[32 + k*8 +: 8] = s[7:0];
                        end
                    end
                end
            end
            if (pop) void'(q.pop_front());
            if (done_e) begin
                if (q.size() < 2) begin
                    q.push_back(w);
                    pushed = 1'b1;
                end else begin
                    dropped = 1'b1;
                    ovf     = 1'b1;
                end
            end
            if (clr_err && !dropped) ovf = 1'b0;
            if (clr_err) wc = 16'd0;
            else if (pushed && wc != 16'hFFFF) wc = wc + 16'd1;
            tick();
            chk("rnd_valid", out_valid, q.size() > 0);
            if (q.size() > 0) chk("rnd_word", out_word, q[0]);
            chk("rnd_done", done, done_e);
            chk("rnd_busy", busy, coll);
            chk("rnd_overflow", overflow, ovf);
`ifdef EDGE_COLLECT_WORD_COUNT_EN
            chk("rnd_word_count", word_count, wc);
`endif
        end
        start = 1'b0; shift_en = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; word_len = 3'd0; shift_en = 1'b0;
        slice_in = 16'h0000; out_ready = 1'b0; clr_err = 1'b0;

        vecs[0] = '{3'd4, 4, {16'hA1B1, 16'hC2D2, 16'hE3F3, 16'h0404}, 64'hA1C2E304_B1D2F304};
        vecs[1] = '{3'd2, 2, {16'h1122, 16'h3344, 16'h0000, 16'h0000}, 64'h11330000_22440000};
        vecs[2] = '{3'd0, 4, {16'h0102, 16'h0304, 16'h0506, 16'h0708}, 64'h01030507_02040608};
        vecs[3] = '{3'd7, 4, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 64'h11223344_11223344};
        vecs[4] = '{3'd1, 1, {16'hABCD, 16'h0000, 16'h0000, 16'h0000}, 64'hAB000000_CD000000};
        vecs[5] = '{3'd3, 3, {16'h1020, 16'h3040, 16'h5060, 16'h0000}, 64'h10305000_20406000};

        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_word", out_word, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
`ifdef EDGE_COLLECT_WORD_COUNT_EN
        chk("rst_word_count", word_count, 16'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();

        // shift_en while idle must not start anything
        beat(16'hFFFF);
        chk("idle_shift_busy", busy, 1'b0);
        chk("idle_shift_valid", out_valid, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].len);
            chk("vec_busy", busy, 1'b1);
            for (int b = 0; b < vecs[i].nbeats; b++) begin
                beat(vecs[i].sl[b]);
                if (b < vecs[i].nbeats - 1) begin
                    chk("vec_done_early", done, 1'b0);
                end else begin
                    chk("vec_done", done, 1'b1);
                    chk("vec_valid", out_valid, 1'b1);
                    chk("vec_word", out_word, vecs[i].exp);
                end
            end
            tick();
            chk("vec_done_pulse", done, 1'b0);
            chk("vec_busy_after", busy, 1'b0);
            chk("vec_hold_word", out_word, vecs[i].exp);
            pop_one();
            chk("vec_popped", out_valid, 1'b0);
        end

        // Backpressure: two retained, third dropped
        word2(16'h0102, 16'h0304);
        word2(16'h0506, 16'h0708);
        chk("bp_no_ovf", overflow, 1'b0);
        word2(16'h0909, 16'h0A0A);
        chk("bp_done_on_drop", done, 1'b1);
        chk("bp_ovf", overflow, 1'b1);
        chk("bp_head1", out_word, 64'h01030000_02040000);
`ifdef EDGE_COLLECT_WORD_COUNT_EN
        chk("bp_word_count", word_count, 16'd2);
`endif
        out_ready = 1'b1;
        tick();
        chk("bp_valid2", out_valid, 1'b1);
        chk("bp_head2", out_word, 64'h05070000_06080000);
        tick();
        chk("bp_empty", out_valid, 1'b0);
        out_ready = 1'b0;
        chk("bp_ovf_sticky", overflow, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("bp_clr", overflow, 1'b0);
`ifdef EDGE_COLLECT_WORD_COUNT_EN
        chk("bp_word_count_clr", word_count, 16'd0);
`endif

        // Push and pop together while full
        word2(16'h0102, 16'h0304);
        word2(16'h0506, 16'h0708);
        do_start(3'd2);
        beat(16'h0B0C);
        out_ready = 1'b1;
        beat(16'h0D0E);
        out_ready = 1'b0;
        chk("pp_no_ovf", overflow, 1'b0);
        chk("pp_head", out_word, 64'h05070000_06080000);
        pop_one();
        chk("pp_third", out_word, 64'h0B0D0000_0C0E0000);
        pop_one();
        chk("pp_empty", out_valid, 1'b0);

        // Restart discards the partial word
        do_start(3'd4);
        beat(16'hDEAD);
        beat(16'hBEEF);
        do_start(3'd4);
        chk("rs_busy", busy, 1'b1);
        chk("rs_no_push", out_valid, 1'b0);
        beat(16'h1122);
        beat(16'h3344);
        beat(16'h5566);
        beat(16'h7788);
        chk("rs_done", done, 1'b1);
        chk("rs_word", out_word, 64'h11335577_22446688);
        pop_one();
        chk("rs_single", out_valid, 1'b0);

        // Restart with a slice in the same cycle: that slice is beat 0
        do_start(3'd4);
        beat(16'hFFFF);
        start = 1'b1; word_len = 3'd2; shift_en = 1'b1; slice_in = 16'hABCD;
        tick();
        start = 1'b0; shift_en = 1'b0;
        chk("rs0_mid", done, 1'b0);
        beat(16'h1234);
        chk("rs0_done", done, 1'b1);
        chk("rs0_word", out_word, 64'hAB120000_CD340000);
        pop_one();

        // Gaps between beats
        do_start(3'd4);
        for (int b = 0; b < 4; b++) begin
            beat(16'h0F10 + 16'(b) * 16'h1010);
            if (b < 3) begin
                chk("gap_done_early", done, 1'b0);
                tick();
                chk("gap_busy", busy, 1'b1);
                chk("gap_hold", out_valid, 1'b0);
            end
        end
        chk("gap_done", done, 1'b1);
        chk("gap_word", out_word, 64'h0F1F2F3F_10203040);
        pop_one();

        // Asynchronous reset mid-word with a word queued
        word2(16'h5555, 16'h6666);
        do_start(3'd4);
        beat(16'h7777);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_word", out_word, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        beat(16'h8888);
        chk("ar_idle", busy, 1'b0);
        chk("ar_still_empty", out_valid, 1'b0);

        random_phase();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
